regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised successor of the processor's register file. It provides two read ports and one write port on a single clock edge, with architectural register 0 hardwired to zero. It also holds a per-register scoreboard (busy bits) so the issue stage can detect pending writebacks. It sits between decode/issue (read plus issue-mark) and writeback (write plus busy-clear).

Parameters:
DATA_W, 32, width of each register in bits
NREG, 32, number of architectural registers (power of two, >= 2)
ADDR_W, 5, address width; must equal log2(NREG)
CNT_W, 6, width of pend_count; must equal log2(NREG)+1

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
rd_addr_a  in  ADDR_W  read port A address
rd_addr_b  in  ADDR_W  read port B address
rd_data_a  out  DATA_W  port A data (combinational from rd_addr_a)
rd_data_b  out  DATA_W  port B data (combinational from rd_addr_b)
rd_busy_a  out  1  register at rd_addr_a has a pending write
rd_busy_b  out  1  register at rd_addr_b has a pending write
wr_en  in  1  writeback strobe
wr_addr  in  ADDR_W  writeback destination
wr_data  in  DATA_W  writeback data
iss_en  in  1  issue request: mark iss_addr busy
iss_addr  in  ADDR_W  destination of the issuing instruction
iss_ready  out  1  issue to iss_addr is accepted this cycle
pend_count  out  CNT_W  number of busy registers (registered)

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - All NREG registers cleared to 0.
  - busy vector cleared; pend_count becomes 0.
  - rst takes priority over any wr_en or iss_en in the same cycle.
  - Reset asserted mid-operation discards all pending busy marks; no writeback is retained.
- After reset, with no stimulus: rd_data_* = 0, rd_busy_* = 0, iss_ready = 1.
- Read ports:
  - rd_data_x = regs[rd_addr_x]; rd_busy_x = busy[rd_addr_x]; both purely combinational, zero-cycle latency.
  - Address 0 always reads 0 and is never busy.
- Write:
  - If wr_en=1 and wr_addr != 0, regs[wr_addr] <= wr_data at the rising edge and busy[wr_addr] is cleared.
  - wr_addr = 0 is ignored entirely.
  - A write to a non-busy register updates data; busy stays 0.
- Issue:
  - iss_ready = (iss_addr == 0) OR NOT busy[iss_addr] OR (wr_en AND wr_addr == iss_addr).
  - If iss_en=1, iss_ready=1 and iss_addr != 0, busy[iss_addr] is set at the rising edge.
  - iss_en with iss_ready=0 produces no state change; the requester must stall and retry.
  - iss_addr = 0 is always accepted and marks nothing.
- Simultaneous write and issue:
  - Same nonzero address: data is written and the register ends busy (the new producer wins; set takes priority over clear).
  - Different addresses: both take effect independently.
- pend_count:
  - Registered; equals the population count of the next busy vector, so it is valid the cycle after the update.
  - Range 0..NREG-1, since register 0 is never busy; no saturation is needed.
- No wrap-around of addresses; all ADDR_W values are legal.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-through forwarding. When wr_en=1 and wr_addr == rd_addr_x != 0, rd_data_x = wr_data and rd_busy_x = 0 in the same cycle.
- Undefined: rd_data_x shows the old contents and rd_busy_x shows the old busy bit until the cycle after the write edge.
- Both modes: stored state, iss_ready and pend_count are identical.

Test Plan:
- Reset, then read all addresses -> every rd_data = 0, rd_busy = 0, pend_count = 0, iss_ready = 1.
- Write 0xDEADBEEF to r5, then read r5 on port A and r0 on port B next cycle -> rd_data_a = 0xDEADBEEF, rd_data_b = 0. Then write 0x1234 to r0 -> r0 still reads 0.
- Issue r7, then issue r7 again -> second cycle iss_ready = 0, rd_busy(r7) = 1, pend_count = 1. Write r7 = 0x55 -> busy clears, pend_count = 0 one cycle later, r7 reads 0x55.
- Same cycle: iss_en on r9 while wr_en on r9 with busy[r9]=1 and wr_data=0xA -> iss_ready = 1; r9 = 0xA and busy[r9] = 1 afterwards; pend_count unchanged at 1.
- Issue r1, r2, r3 in three cycles, then assert rst together with wr_en on r1 -> all busy bits 0, pend_count = 0, r1 = 0 after reset.
- Bypass: wr_en on r4 = 0x77 with rd_addr_a = 4 in the same cycle -> with REGFILE_BYPASS_EN, rd_data_a = 0x77 that cycle; without it, the old value that cycle and 0x77 the next.

Source files
------------

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : 2R/1W register file with r0 hardwired to zero, a per-register
//            busy scoreboard and a registered count of pending writebacks.
//            Define REGFILE_BYPASS_EN to forward writeback data and busy
//            state straight to the read ports.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              iss_ready,
  output logic [CNT_W-1:0]  pend_count
);

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_busy;
  logic [CNT_W-1:0]  r_pend_count;

  logic              w_wr_ok;
  logic              w_iss_ok;
  logic [NREG-1:0]   w_busy_next;
  logic [CNT_W-1:0]  w_pop;

  assign w_wr_ok   = wr_en && (wr_addr != '0);
  // A writeback to the same register in this cycle frees it for reissue.
  assign iss_ready = (iss_addr == '0) || !r_busy[iss_addr] ||
                     (wr_en && (wr_addr == iss_addr));
  assign w_iss_ok  = iss_en && iss_ready && (iss_addr != '0);

  // Set is applied after clear so a new producer wins over the retiring one.
  always_comb begin
    w_busy_next = r_busy;
    if (w_wr_ok)
      w_busy_next[wr_addr] = 1'b0;
    if (w_iss_ok)
      w_busy_next[iss_addr] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_comb begin
    w_pop = '0;
    for (int i = 1; i < NREG; i++)
      w_pop = w_pop + CNT_W'(w_busy_next[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
      r_busy       <= '0;
      r_pend_count <= '0;
    end else begin
      if (w_wr_ok)
        r_regs[wr_addr] <= wr_data;
      r_busy       <= w_busy_next;
      r_pend_count <= w_pop;
    end
  end

  assign pend_count = r_pend_count;

`ifdef REGFILE_BYPASS_EN
  logic w_fwd_a;
  logic w_fwd_b;

  assign w_fwd_a   = w_wr_ok && (wr_addr == rd_addr_a);
  assign w_fwd_b   = w_wr_ok && (wr_addr == rd_addr_b);
  assign rd_data_a = (rd_addr_a == '0) ? '0 : (w_fwd_a ? wr_data : r_regs[rd_addr_a]);
  assign rd_data_b = (rd_addr_b == '0) ? '0 : (w_fwd_b ? wr_data : r_regs[rd_addr_b]);
  assign rd_busy_a = (rd_addr_a != '0) && !w_fwd_a && r_busy[rd_addr_a];
  assign rd_busy_b = (rd_addr_b != '0) && !w_fwd_b && r_busy[rd_addr_b];
`else
  assign rd_data_a = (rd_addr_a == '0) ? '0 : r_regs[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : r_regs[rd_addr_b];
  assign rd_busy_a = (rd_addr_a != '0) && r_busy[rd_addr_a];
  assign rd_busy_b = (rd_addr_b != '0) && r_busy[rd_addr_b];
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Self-checking bench for regfile_sb: directed scenarios plus a
//            randomized run against an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] rd_addr_a, rd_addr_b;
  logic [DATA_W-1:0] rd_data_a, rd_data_b;
  logic              rd_busy_a, rd_busy_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic              iss_ready;
  logic [CNT_W-1:0]  pend_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [DATA_W-1:0] m_regs [NREG];
  bit                m_busy [NREG];
  int                m_count;

  regfile_sb #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .pend_count(pend_count)
  );

  always #5 clk = ~clk;

  function automatic bit exp_ready();
    return (iss_addr == 0) || !m_busy[iss_addr] || (wr_en && wr_addr == iss_addr);
  endfunction

  function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_data;
`endif
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input logic [ADDR_W-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  // Apply one rising edge to the model using the currently driven inputs.
  task automatic model_edge();
    bit ready;
    ready = exp_ready();
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_regs[wr_addr] = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (iss_en && ready && iss_addr != 0)
        m_busy[iss_addr] = 1'b1;
    end
    m_count = 0;
    for (int i = 0; i < NREG; i++)
      m_count += int'(m_busy[i]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      rd_addr_a = ADDR_W'(i); rd_addr_b = ADDR_W'(NREG-1-i); iss_addr = ADDR_W'(i);
      #1;
      n_cmp++;
      if (rd_data_a !== '0 || rd_data_b !== '0 || rd_busy_a !== 1'b0 ||
          rd_busy_b !== 1'b0 || iss_ready !== 1'b1 || pend_count !== '0) begin
        n_bad++;
        $display("FAIL reset_state addr=%0d got a=%h b=%h ba=%b bb=%b rdy=%b cnt=%0d want 0/0/0/0/1/0",
                 i, rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, iss_ready, pend_count);
      end
    end
    iss_addr = '0;
  endtask

  task automatic test_write();
    idle();
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    step();
    idle();
    rd_addr_a = 5; rd_addr_b = 0;
    #1;
    n_cmp++;
    if (rd_data_a !== 32'hDEADBEEF || rd_data_b !== '0) begin
      n_bad++;
      $display("FAIL write_r5 got a=%h b=%h want deadbeef/0", rd_data_a, rd_data_b);
    end
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'h1234;
    step();
    idle();
    rd_addr_a = 0;
    #1;
    n_cmp++;
    if (rd_data_a !== '0 || rd_busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL write_r0 got %h busy=%b want 0/0", rd_data_a, rd_busy_a);
    end
  endtask

  task automatic test_issue();
    idle();
    iss_en = 1'b1; iss_addr = 7;
    #1;
    n_cmp++;
    if (iss_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL issue_first ready got %b want 1", iss_ready);
    end
    step();
    rd_addr_a = 7;
    #1;
    n_cmp++;
    if (iss_ready !== 1'b0 || rd_busy_a !== 1'b1 || pend_count !== CNT_W'(1)) begin
      n_bad++;
      $display("FAIL issue_again got rdy=%b busy=%b cnt=%0d want 0/1/1", iss_ready, rd_busy_a, pend_count);
    end
    step();
    n_cmp++;
    if (pend_count !== CNT_W'(1)) begin
      n_bad++;
      $display("FAIL issue_stall cnt got %0d want 1", pend_count);
    end
    idle();
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'h55;
    step();
    idle();
    #1;
    n_cmp++;
    if (pend_count !== '0 || rd_busy_a !== 1'b0 || rd_data_a !== 32'h55) begin
      n_bad++;
      $display("FAIL issue_clear got cnt=%0d busy=%b data=%h want 0/0/55", pend_count, rd_busy_a, rd_data_a);
    end
  endtask

  task automatic test_same_cycle();
    idle();
    iss_en = 1'b1; iss_addr = 9;
    step();
    iss_en = 1'b1; iss_addr = 9; wr_en = 1'b1; wr_addr = 9; wr_data = 32'hA;
    #1;
    n_cmp++;
    if (iss_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL same_cycle ready got %b want 1", iss_ready);
    end
    step();
    idle();
    rd_addr_b = 9;
    #1;
    n_cmp++;
    if (rd_data_b !== 32'hA || rd_busy_b !== 1'b1 || pend_count !== CNT_W'(1)) begin
      n_bad++;
      $display("FAIL same_cycle_after got data=%h busy=%b cnt=%0d want a/1/1", rd_data_b, rd_busy_b, pend_count);
    end
    wr_en = 1'b1; wr_addr = 9; wr_data = 32'hB;
    step();
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    for (int i = 1; i <= 3; i++) begin
      iss_en = 1'b1; iss_addr = ADDR_W'(i);
      step();
    end
    n_cmp++;
    if (pend_count !== CNT_W'(3)) begin
      n_bad++;
      $display("FAIL reset_mid_pre cnt got %0d want 3", pend_count);
    end
    idle();
    rst = 1'b1; wr_en = 1'b1; wr_addr = 1; wr_data = 32'hCAFE;
    step();
    idle();
    for (int i = 1; i <= 3; i++) begin
      rd_addr_a = ADDR_W'(i);
      #1;
      n_cmp++;
      if (rd_busy_a !== 1'b0 || rd_data_a !== '0 || pend_count !== '0) begin
        n_bad++;
        $display("FAIL reset_mid r%0d got busy=%b data=%h cnt=%0d want 0/0/0", i, rd_busy_a, rd_data_a, pend_count);
      end
    end
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 1'b1; wr_addr = 4; wr_data = 32'h11;
    step();
    wr_data = 32'h77; rd_addr_a = 4;
    #1;
    n_cmp++;
`ifdef REGFILE_BYPASS_EN
    if (rd_data_a !== 32'h77) begin
      n_bad++;
      $display("FAIL bypass_same got %h want 77", rd_data_a);
    end
`else
    if (rd_data_a !== 32'h11) begin
      n_bad++;
      $display("FAIL bypass_same got %h want 11", rd_data_a);
    end
`endif
    step();
    idle();
    #1;
    n_cmp++;
    if (rd_data_a !== 32'h77) begin
      n_bad++;
      $display("FAIL bypass_next got %h want 77", rd_data_a);
    end
  endtask

  // Small address pool forces frequent issue/write collisions.
  function automatic logic [ADDR_W-1:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return ADDR_W'($urandom_range(0, NREG-1));
    return ADDR_W'($urandom_range(0, 6));
  endfunction

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_addr   = pick_addr();
      wr_data   = $urandom;
      iss_en    = ($urandom_range(0, 2) != 0);
      iss_addr  = pick_addr();
      rd_addr_a = ($urandom_range(0, 1) == 1) ? wr_addr : pick_addr();
      rd_addr_b = ($urandom_range(0, 1) == 1) ? iss_addr : pick_addr();
      #1;
      n_cmp++;
      if (rd_data_a !== exp_data(rd_addr_a) || rd_data_b !== exp_data(rd_addr_b) ||
          rd_busy_a !== exp_busy(rd_addr_a) || rd_busy_b !== exp_busy(rd_addr_b) ||
          iss_ready !== exp_ready()) begin
        n_bad++;
        $display("FAIL random_comb cyc=%0d got a=%h b=%h ba=%b bb=%b rdy=%b want %h %h %b %b %b",
                 c, rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, iss_ready,
                 exp_data(rd_addr_a), exp_data(rd_addr_b), exp_busy(rd_addr_a),
                 exp_busy(rd_addr_b), exp_ready());
      end
      step();
      n_cmp++;
      if (pend_count !== CNT_W'(m_count)) begin
        n_bad++;
        $display("FAIL random_count cyc=%0d got %0d want %0d", c, pend_count, m_count);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    rd_addr_a = '0; rd_addr_b = '0;
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_count = 0;
    #2;
    test_reset();
    test_write();
    test_issue();
    test_same_cycle();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
